// File: rtl/spi_parity_frame_ctrl.sv
// SPI frame transmitter: SETUP, DATA_W payload bits MSB first, odd-parity bit, HOLD.
// Latency: cs drops the cycle after acceptance; done pulses CLK_DIV*(2*DATA_W+4)+1 cycles after acceptance.
// Backpressure: tx_ready is high only in IDLE; tx_valid while busy is ignored.
module spi_parity_frame_ctrl #(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_ready,
  output logic              cs,
  output logic              sclk,
  output logic              sample,
  output logic              mosi,
  output logic              busy,
  output logic              done,
  output logic              parity_out
);

  localparam int CW = $clog2(2 * CLK_DIV) + 1;
  localparam int BW = $clog2(DATA_W) + 1;
  localparam logic [CW-1:0] HALF      = CW'(CLK_DIV);
  localparam logic [CW-1:0] LAST_HALF = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] LAST_PER  = CW'(2 * CLK_DIV - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    SHIFT  = 3'd2,
    PARITY = 3'd3,
    HOLD   = 3'd4
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CW-1:0]     cnt;
  logic [BW-1:0]     bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic              par;

  logic accept;
  logic per_end;
  logic frame_end;

  assign accept    = (state == IDLE) && tx_valid;
  assign per_end   = (cnt == LAST_PER);
  assign frame_end = (state == HOLD) && (cnt == LAST_HALF);

  // State register; reset wins over any acceptance in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state: phase lengths counted by cnt, payload bits by bit_cnt.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (tx_valid)                           state_nxt = SETUP;
      SETUP:   if (cnt == LAST_HALF)                   state_nxt = SHIFT;
      SHIFT:   if (per_end && (bit_cnt == LAST_BIT))   state_nxt = PARITY;
      PARITY:  if (per_end)                            state_nxt = HOLD;
      HOLD:    if (cnt == LAST_HALF)                   state_nxt = IDLE;
      default:                                         state_nxt = IDLE;
    endcase
  end

  // Cycle counter restarts on every state change and at each SHIFT bit boundary.
  always_ff @(posedge clk) begin
    if (reset)                           cnt <= '0;
    else if (state_nxt != state)         cnt <= '0;
    else if (state == IDLE)              cnt <= '0;
    else if ((state == SHIFT) && per_end) cnt <= '0;
    else                                 cnt <= cnt + CW'(1);
  end

  // Payload capture, MSB-first shifting and running odd parity.
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg   <= '0;
      par     <= 1'b1;
      bit_cnt <= '0;
    end else if (accept) begin
      shreg   <= tx_data;
      par     <= 1'b1;
      bit_cnt <= '0;
    end else if ((state == SHIFT) && per_end) begin
      shreg   <= shreg << 1;
      par     <= par ^ shreg[DATA_W-1];
      bit_cnt <= bit_cnt + BW'(1);
    end
  end

  // Completion strobe and published parity; both land on the first IDLE cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      done       <= 1'b0;
      parity_out <= 1'b1;
    end else begin
      done <= frame_end;
      if (frame_end) parity_out <= par;
    end
  end

  // Serial outputs decoded from state and position within the bit period.
  always_comb begin
    tx_ready = 1'b0;
    cs       = 1'b1;
    sclk     = 1'b0;
    sample   = 1'b0;
    mosi     = 1'b0;
    busy     = 1'b1;
    case (state)
      IDLE: begin
        tx_ready = 1'b1;
        busy     = 1'b0;
      end
      SETUP: begin
        cs   = 1'b0;
        mosi = shreg[DATA_W-1];
      end
      SHIFT: begin
        cs     = 1'b0;
        mosi   = shreg[DATA_W-1];
        sclk   = (cnt >= HALF);
        sample = (cnt == HALF);
      end
      PARITY: begin
        cs     = 1'b0;
        mosi   = par;
        sclk   = (cnt >= HALF);
        sample = (cnt == HALF);
      end
      HOLD: begin
        cs = 1'b0;
      end
      default: begin
        cs = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_spi_parity_frame_ctrl.sv
// Directed bench for spi_parity_frame_ctrl at DATA_W=8, CLK_DIV=4.
// Outputs are sampled 1 ns after each rising edge; inputs change at the same point.
// Every wait is a fixed cycle count, so the run always ends.
module tb_spi_parity_frame_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready, cs, sclk, sample, mosi, busy, done, parity_out;

  int checks = 0;
  int errors = 0;

  spi_parity_frame_ctrl #(.DATA_W(8), .CLK_DIV(4)) dut (
    .clk(clk), .reset(reset), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .cs(cs), .sclk(sclk), .sample(sample), .mosi(mosi),
    .busy(busy), .done(done), .parity_out(parity_out)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Current cycle is the acceptance cycle T. Walks the 80 cs-low cycles and ends
  // on the done cycle T+81. With chain set, tx_valid stays high and tx_data is
  // switched to next_data so the next frame is accepted in the done cycle.
  // With disturb set, tx_data and tx_valid are toggled mid-frame.
  task automatic frame(input string tag, input logic [7:0] data, input logic exp_par,
                       input bit chain, input logic [7:0] next_data, input bit disturb);
    logic [8:0] bits;
    int n_low, n_samp, n_bad, n_busy;
    bits = '0; n_low = 0; n_samp = 0; n_bad = 0; n_busy = 0;
    tx_valid = 1'b1;
    tx_data  = data;
    chk({tag, "_ready"}, tx_ready, 1'b1);
    step();
    if (!chain) tx_valid = 1'b0;
    else        tx_data  = next_data;
    chk({tag, "_setup_mosi"}, mosi, data[7]);
    for (int c = 1; c <= 80; c++) begin
      if (disturb && c == 20) begin tx_valid = 1'b1; tx_data = ~data; end
      if (disturb && c == 21) tx_valid = 1'b0;
      if (cs == 1'b0) n_low++;
      if (busy == 1'b1) n_busy++;
      if (sample) begin
        n_samp++;
        bits = {bits[7:0], mosi};
        if (sclk !== 1'b1) n_bad++;
      end
      step();
    end
    chk({tag, "_cs_low_cycles"}, n_low, 80);
    chk({tag, "_busy_cycles"}, n_busy, 80);
    chk({tag, "_samples"}, n_samp, 9);
    chk({tag, "_sample_sclk"}, n_bad, 0);
    chk({tag, "_bits"}, bits, {data, exp_par});
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_cs_done"}, cs, 1'b1);
    chk({tag, "_parity_out"}, parity_out, exp_par);
  endtask

  initial begin
    int done_seen;
    reset = 1'b1; tx_valid = 1'b0; tx_data = 8'h00;
    step(); step();
    chk("rst_cs", cs, 1'b1);
    chk("rst_sclk", sclk, 1'b0);
    chk("rst_mosi", mosi, 1'b0);
    chk("rst_sample", sample, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_ready", tx_ready, 1'b1);
    chk("rst_parity", parity_out, 1'b1);
    reset = 1'b0;
    step();

    frame("a5", 8'hA5, 1'b1, 1'b0, 8'h00, 1'b0);
    step();
    chk("a5_done_once", done, 1'b0);

    frame("07", 8'h07, 1'b0, 1'b0, 8'h00, 1'b0);
    step();
    frame("00", 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
    step();
    frame("ff", 8'hFF, 1'b1, 1'b0, 8'h00, 1'b0);
    step();

    // Back-to-back: second frame accepted in the first frame's done cycle.
    frame("b2b_01", 8'h01, 1'b0, 1'b1, 8'h03, 1'b0);
    frame("b2b_03", 8'h03, 1'b1, 1'b0, 8'h00, 1'b0);
    step();
    chk("b2b_idle_after", busy, 1'b0);

    // Busy-time tx_valid/tx_data activity must not alter the frame or queue another.
    frame("dist", 8'h3C, 1'b1, 1'b0, 8'h00, 1'b1);
    step();
    chk("dist_no_extra_busy", busy, 1'b0);
    chk("dist_no_extra_cs", cs, 1'b1);

    // Mid-frame reset at T+40 of a 0x07 frame: parity_out stays at the 0x3C value 1.
    tx_valid = 1'b1; tx_data = 8'h07;
    step();
    tx_valid = 1'b0;
    for (int c = 1; c < 40; c++) step();
    chk("abort_busy_before", busy, 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_cs", cs, 1'b1);
    chk("abort_busy", busy, 1'b0);
    chk("abort_parity", parity_out, 1'b1);
    done_seen = 0;
    for (int c = 0; c < 60; c++) begin
      if (done) done_seen++;
      step();
    end
    chk("abort_no_done", done_seen, 0);
    chk("abort_parity_late", parity_out, 1'b1);

    // Reset with simultaneous acceptance: reset wins.
    reset = 1'b1; tx_valid = 1'b1; tx_data = 8'h07;
    step();
    reset = 1'b0; tx_valid = 1'b0;
    chk("rst_prio_busy", busy, 1'b0);
    chk("rst_prio_cs", cs, 1'b1);
    step();
    chk("rst_prio_stay_idle", busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
